// File: rtl/mu0x_datapath.sv
`default_nettype none
// ============================================================================
// Module      : mu0x_datapath
// Description : MU0-style datapath (PC, IR, Acc, ALU, flags) with an
//               iterative unsigned shift-add multiplier sharing the Acc.
// Revision    : 1.0 - initial release
// ============================================================================
module mu0x_datapath #(
    parameter int DW = 16,
    parameter int AW = 12
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [DW-1:0]    Din,
    input  logic             X_sel,
    input  logic             Y_sel,
    input  logic             Addr_sel,
    input  logic             PC_En,
    input  logic             IR_En,
    input  logic             Acc_En,
    input  logic [2:0]       M,
    input  logic             Mul_Start,
    output logic [DW-AW-1:0] F,
    output logic [AW-1:0]    Address,
    output logic [DW-1:0]    Dout,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic [AW-1:0]    PC,
    output logic [DW-1:0]    Acc,
    output logic             Mul_Busy,
    output logic             Mul_Done
);

    localparam int OPW = DW - AW;
    localparam int CW  = $clog2(DW) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mul_state_t;

    mul_state_t      state_q, state_d;
    logic [AW-1:0]   pc_q;
    logic [DW-1:0]   ir_q;
    logic [DW-1:0]   acc_q;
    logic            c_q;
    logic            done_q;
    logic [2*DW-1:0] mcand_q;
    logic [DW-1:0]   mplier_q;
    logic [2*DW-1:0] prod_q;
    logic [CW-1:0]   cnt_q;

    logic [DW-1:0]   x_d, y_d;
    logic [DW:0]     sum_d, inc_d, diff_d;
    logic [DW-1:0]   alu_d;
    logic            alu_c_d;
    logic [2*DW-1:0] prod_d;
    logic            mul_load_d, mul_last_d;

    assign x_d = X_sel ? {{OPW{1'b0}}, pc_q} : acc_q;
    assign y_d = Y_sel ? {{OPW{1'b0}}, ir_q[AW-1:0]} : Din;

    assign sum_d  = {1'b0, x_d} + {1'b0, y_d};
    assign inc_d  = {1'b0, x_d} + {{DW{1'b0}}, 1'b1};
    assign diff_d = {1'b0, x_d} - {1'b0, y_d};

    always_comb begin
        alu_d   = '0;
        alu_c_d = 1'b0;
        case (M)
            3'b000: alu_d = y_d;
            3'b001: begin alu_d = sum_d[DW-1:0];  alu_c_d = sum_d[DW];   end
            3'b010: begin alu_d = inc_d[DW-1:0];  alu_c_d = inc_d[DW];   end
            // Carry on subtract is "no borrow", i.e. X >= Y unsigned.
            3'b011: begin alu_d = diff_d[DW-1:0]; alu_c_d = ~diff_d[DW]; end
            3'b100: alu_d = x_d & y_d;
            3'b101: alu_d = x_d | y_d;
            3'b110: begin alu_d = {x_d[DW-2:0], 1'b0};     alu_c_d = x_d[DW-1]; end
            default: begin alu_d = {x_d[DW-1], x_d[DW-1:1]}; alu_c_d = x_d[0];  end
        endcase
    end

    assign prod_d = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

    always_comb begin
        state_d    = state_q;
        mul_load_d = 1'b0;
        mul_last_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Mul_Start) begin
                    mul_load_d = 1'b1;
                    state_d    = S_RUN;
                end
            end
            default: begin
                if (cnt_q == LAST_ITER) begin
                    mul_last_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q     <= '0;
            ir_q     <= '0;
            acc_q    <= '0;
            c_q      <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= mul_last_d;
            if (PC_En) pc_q <= alu_d[AW-1:0];
            if (IR_En) ir_q <= Din;

            // The multiplier owns Acc while running; Acc_En only acts in IDLE.
            if (mul_last_d) begin
                acc_q <= prod_d[DW-1:0];
                c_q   <= |prod_d[2*DW-1:DW];
            end else if (state_q == S_IDLE && Acc_En) begin
                acc_q <= alu_d;
                c_q   <= alu_c_d;
            end

            if (mul_load_d) begin
                mcand_q  <= {{DW{1'b0}}, acc_q};
                mplier_q <= Din;
                prod_q   <= '0;
                cnt_q    <= '0;
            end else if (state_q == S_RUN) begin
                prod_q   <= prod_d;
                mcand_q  <= {mcand_q[2*DW-2:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[DW-1:1]};
                cnt_q    <= cnt_q + 1'b1;
            end
        end
    end

    assign F        = ir_q[DW-1:AW];
    assign Address  = Addr_sel ? ir_q[AW-1:0] : pc_q;
    assign Dout     = x_d;
    assign N        = acc_q[DW-1];
    assign Z        = (acc_q == '0);
    assign C        = c_q;
    assign PC       = pc_q;
    assign Acc      = acc_q;
    assign Mul_Busy = (state_q == S_RUN);
    assign Mul_Done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mu0x_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_mu0x_datapath
// Description : Self-checking bench for mu0x_datapath against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mu0x_datapath;

    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int MASK  = 32'h0000_FFFF;
    localparam int AMASK = 32'h0000_0FFF;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [DW-1:0] Din;
    logic          X_sel, Y_sel, Addr_sel;
    logic          PC_En, IR_En, Acc_En;
    logic [2:0]    M;
    logic          Mul_Start;
    logic [3:0]    F;
    logic [AW-1:0] Address;
    logic [DW-1:0] Dout;
    logic          N, Z, C;
    logic [AW-1:0] PC;
    logic [DW-1:0] Acc;
    logic          Mul_Busy, Mul_Done;

    mu0x_datapath #(.DW(DW), .AW(AW)) dut (
        .Clk(Clk), .Reset(Reset), .Din(Din),
        .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel),
        .PC_En(PC_En), .IR_En(IR_En), .Acc_En(Acc_En),
        .M(M), .Mul_Start(Mul_Start),
        .F(F), .Address(Address), .Dout(Dout),
        .N(N), .Z(Z), .C(C), .PC(PC), .Acc(Acc),
        .Mul_Busy(Mul_Busy), .Mul_Done(Mul_Done)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state plus a cycles-remaining counter
    // and a product computed up front with plain multiplication.
    int     m_pc, m_ir, m_acc, m_c, m_busy, m_rem, m_done;
    longint m_prod;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int x, y, r, cr, acc_old;
        if (!Reset) begin
            m_pc = 0; m_ir = 0; m_acc = 0; m_c = 0;
            m_busy = 0; m_rem = 0; m_done = 0; m_prod = 0;
            return;
        end
        x  = X_sel ? m_pc : m_acc;
        y  = Y_sel ? (m_ir & AMASK) : int'(Din);
        r  = 0;
        cr = 0;
        case (M)
            3'd0: r = y;
            3'd1: begin r = (x + y) & MASK; cr = ((x + y) >> 16) & 1; end
            3'd2: begin r = (x + 1) & MASK; cr = ((x + 1) >> 16) & 1; end
            3'd3: begin r = (x - y) & MASK; cr = (x >= y) ? 1 : 0; end
            3'd4: r = x & y;
            3'd5: r = x | y;
            3'd6: begin r = (x << 1) & MASK; cr = (x >> 15) & 1; end
            default: begin r = (x >> 1) | (x & 'h8000); cr = x & 1; end
        endcase
        acc_old = m_acc;
        m_done  = 0;
        if (PC_En) m_pc = r & AMASK;
        if (IR_En) m_ir = int'(Din);
        if (m_busy != 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_acc  = int'(m_prod & MASK);
                m_c    = ((m_prod >> 16) != 0) ? 1 : 0;
                m_busy = 0;
                m_done = 1;
            end
        end else begin
            if (Acc_En) begin m_acc = r; m_c = cr; end
            if (Mul_Start) begin
                m_prod = longint'(acc_old) * longint'(Din);
                m_busy = 1;
                m_rem  = DW;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("pc",   PC,       m_pc);
        check_eq("acc",  Acc,      m_acc);
        check_eq("c",    C,        m_c);
        check_eq("n",    N,        (m_acc >> 15) & 1);
        check_eq("z",    Z,        (m_acc == 0) ? 1 : 0);
        check_eq("f",    F,        m_ir >> 12);
        check_eq("busy", Mul_Busy, m_busy);
        check_eq("done", Mul_Done, m_done);
        check_eq("addr", Address,  Addr_sel ? (m_ir & AMASK) : m_pc);
        check_eq("dout", Dout,     X_sel ? m_pc : m_acc);
    endtask

    task automatic cycle();
        model_step();
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    task automatic quiet();
        PC_En = 0; IR_En = 0; Acc_En = 0; Mul_Start = 0;
        X_sel = 0; Y_sel = 0; Addr_sel = 0; M = 3'd0;
    endtask

    task automatic load_acc(input int v);
        quiet();
        Din = DW'(v); Acc_En = 1;
        cycle();
        Acc_En = 0;
    endtask

    // Starts a multiply; optionally pokes Acc_En/Mul_Start/IR_En during RUN.
    task automatic run_mul(input int a, input int d, input bit poke, output int bc, output int dc);
        load_acc(a);
        Din = DW'(d); Mul_Start = 1;
        cycle();
        Mul_Start = 0;
        bc = int'(Mul_Busy);
        dc = 0;
        for (int i = 0; i < 24; i++) begin
            if (poke && i < 5) begin
                Acc_En = 1; M = 3'd0; Mul_Start = 1; IR_En = 1; Din = 16'h5123;
            end else begin
                quiet();
            end
            cycle();
            bc += int'(Mul_Busy);
            dc += int'(Mul_Done);
        end
    endtask

    initial begin
        int bc, dc;
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, dc;
        Reset = 0; Din = 16'hBEEF; X_sel = 1; Y_sel = 1; Addr_sel = 1;
        PC_En = 1; IR_En = 1; Acc_En = 1; M = 3'd2; Mul_Start = 1;
        cycle();
        check_eq("rst_state", {PC, Acc, Dout, Z, N, C, Mul_Busy}, {12'h000, 16'h0000, 16'h0000, 4'b1000});

        Reset = 1;
        load_acc('h1234);
        quiet(); Din = 16'h0FFF; PC_En = 1;
        cycle();
        check_eq("pc_load", PC, 12'hFFF);
        X_sel = 1; M = 3'd2;
        cycle();
        check_eq("pc_wrap", {PC, Acc}, {12'h000, 16'h1234});

        load_acc('hFFFF);
        quiet(); Din = 16'h0001; M = 3'd1; Acc_En = 1;
        cycle();
        check_eq("add_carry", {Acc, Z, C}, {16'h0000, 2'b11});
        M = 3'd3;
        cycle();
        check_eq("sub_borrow", {Acc, N, C}, {16'hFFFF, 2'b10});

        run_mul('h0007, 'h0009, 1'b0, bc, dc);
        check_eq("mul7x9", {Acc, C}, {16'h003F, 1'b0});
        check_eq("mul7x9_busy", bc, 16);
        check_eq("mul7x9_done", dc, 1);
        run_mul('h0100, 'h0100, 1'b0, bc, dc);
        check_eq("mul_ovf", {Acc, Z, C}, {16'h0000, 2'b11});
        check_eq("mul_ovf_done", dc, 1);

        run_mul('h0123, 'h0045, 1'b1, bc, dc);
        check_eq("mul_ignore", Acc, 16'h4E6F);
        check_eq("mul_ir", {IR_F_pack(F), 16'h0}, {4'h5, 16'h0});
        check_eq("mul_ir_done", dc, 1);

        load_acc('h0003);
        Din = 16'h0005; Mul_Start = 1;
        cycle();
        Mul_Start = 0;
        for (int i = 0; i < 4; i++) cycle();
        Reset = 0;
        cycle();
        check_eq("abort", {Mul_Busy, Acc}, {1'b0, 16'h0000});
        Reset = 1;
        dc = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            dc += int'(Mul_Done);
        end
        check_eq("abort_nodone", dc, 0);

        for (int i = 0; i < 600; i++) begin
            Reset     = ($urandom_range(0, 59) != 0);
            Din       = DW'($urandom);
            X_sel     = 1'($urandom);
            Y_sel     = 1'($urandom);
            Addr_sel  = 1'($urandom);
            PC_En     = 1'($urandom);
            IR_En     = 1'($urandom);
            Acc_En    = ($urandom_range(0, 2) == 0);
            M         = 3'($urandom);
            Mul_Start = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [3:0] IR_F_pack(input logic [3:0] f);
        return f;
    endfunction

endmodule
`default_nettype wire

// File: doc/mu0x_datapath.md
MU0X_DATAPATH -- requirements
Module: mu0x_datapath

Interface
REQ-001 Parameter DW, default 16: data/register width, legal values 8..32.
REQ-002 Parameter AW, default 12: address/PC width, legal values 4..DW-2; opcode field width OPW = DW-AW.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 Din  input  DW  memory read data.
REQ-006 X_sel, Y_sel, Addr_sel  input  1 each  mux selects.
REQ-007 PC_En, IR_En, Acc_En  input  1 each  register write enables.
REQ-008 M  input  3  ALU operation select.
REQ-009 Mul_Start  input  1  request iterative multiply.
REQ-010 F  output  OPW  IR[DW-1:AW].
REQ-011 Address  output  AW  memory address.
REQ-012 Dout  output  DW  equals X.
REQ-013 N, Z, C  output  1 each  negative, zero, carry flags.
REQ-014 PC  output  AW; Acc  output  DW  register contents.
REQ-015 Mul_Busy  output  1  multiplier active; Mul_Done  output  1  one-cycle completion pulse.

Function
REQ-016 X = Acc when X_sel=0, else PC zero-extended to DW.
REQ-017 Y = Din when Y_sel=0, else IR[AW-1:0] zero-extended to DW.
REQ-018 Address = PC when Addr_sel=0, else IR[AW-1:0].
REQ-019 ALU result by M: 000 Y; 001 X+Y; 010 X+1; 011 X-Y; 100 X&Y; 101 X|Y; 110 X<<1; 111 X arithmetic >>1; all truncated to DW bits.
REQ-020 ALU carry-out: add/inc = bit DW of the sum; sub = NOT borrow (1 when X>=Y unsigned); shift-left = X[DW-1]; shift-right = X[0]; 000/100/101 = 0.
REQ-021 PC_En: PC <= ALU[AW-1:0] (wraps modulo 2^AW); IR_En: IR <= Din; Acc_En: Acc <= ALU and C <= ALU carry-out.
REQ-022 N = Acc[DW-1] and Z = (Acc==0), combinational from Acc.
REQ-023 Multiplier states: IDLE, RUN; Mul_Busy=1 exactly in RUN.
REQ-024 IDLE with Mul_Start=1 at edge k: latch multiplicand = Acc value before edge k, multiplier = Din; clear partial product; enter RUN; iteration counter = 0.
REQ-025 RUN: one shift-add iteration per edge (edges k+1..k+DW); at edge k+DW, Acc <= low DW bits of product, C <= 1 if high DW bits nonzero else 0, return to IDLE.
REQ-026 Mul_Done = 1 for exactly the one cycle following edge k+DW, 0 otherwise.
REQ-027 In RUN, Acc_En and Mul_Start are ignored; PC_En and IR_En act normally.
REQ-028 Mul_Start and Acc_En together in IDLE: Acc_En write occurs at that edge; multiply uses pre-edge Acc.
REQ-029 Mul_Done cycle is in IDLE: a new Mul_Start there is accepted.
REQ-030 Multiply is unsigned; product of DW x DW held internally at 2*DW bits.

Reset
REQ-031 Reset=0 at an edge: PC=0, IR=0, Acc=0, C=0, multiplier to IDLE, Mul_Busy=0, Mul_Done=0, internal multiplier registers cleared; hence N=0, Z=1, F=0.
REQ-032 Reset overrides all enables and Mul_Start, including mid-RUN (multiply aborted, no Mul_Done, Acc not written with partial result).

Verification (DW=16, AW=12)
REQ-033 Reset low one edge with all enables high -> PC=0x000, Acc=0x0000, IR=0x0000, Z=1, N=0, C=0, Mul_Busy=0.
REQ-034 PC=0xFFF, X_sel=1, M=010, PC_En=1 -> PC=0x000, Acc unchanged.
REQ-035 Acc=0xFFFF, Din=0x0001, Y_sel=0, M=001, Acc_En=1 -> Acc=0x0000, Z=1, C=1; then M=011 with Din=0x0001 -> Acc=0xFFFF, N=1, C=0.
REQ-036 Acc=0x0007, Din=0x0009, Mul_Start one cycle -> Mul_Busy high 16 cycles, Acc=0x003F, C=0, Mul_Done single pulse; repeat with Acc=0x0100, Din=0x0100 -> Acc=0x0000, Z=1, C=1.
REQ-037 During RUN assert Acc_En with M=000 and Mul_Start -> both ignored, final Acc = product; IR_En with Din=0x5123 -> IR=0x5123, F=0x5.
REQ-038 Reset low at 5th RUN cycle -> Mul_Busy=0 next cycle, Acc=0x0000, Mul_Done never asserted.
